// File: rtl/bcd_scan_ctrl_pkg.sv
// Shared types and constants for the BCD conversion and display scan path.
// Latency: none; this package holds declarations only.
// Backpressure: not applicable.
package bcd_scan_ctrl_pkg;

   localparam int DATA_W = 14;
   localparam logic [DATA_W-1:0] BCD_MAX = 14'd9999;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CONV = 1'b1
   } state_t;

   // Active-high segment patterns: bit7 = dp, bits6:0 = g..a
   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   // Digit to segment pattern; non-decimal codes cannot occur and show blank
   function automatic logic [7:0] seg_pattern(input logic [3:0] digit);
      case (digit)
         4'd0:    seg_pattern = SEG_0;
         4'd1:    seg_pattern = SEG_1;
         4'd2:    seg_pattern = SEG_2;
         4'd3:    seg_pattern = SEG_3;
         4'd4:    seg_pattern = SEG_4;
         4'd5:    seg_pattern = SEG_5;
         4'd6:    seg_pattern = SEG_6;
         4'd7:    seg_pattern = SEG_7;
         4'd8:    seg_pattern = SEG_8;
         4'd9:    seg_pattern = SEG_9;
         default: seg_pattern = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bcd_scan_ctrl_if.sv
// Input value handshake into the BCD scan controller.
// Latency: none; this interface holds wires only.
// Backpressure: producer holds in_valid/in_data until it sees in_ready high at an edge.
interface bcd_scan_ctrl_if;
   import bcd_scan_ctrl_pkg::*;

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/bcd_scan_ctrl_div10_step.sv
// One combinational divide-by-ten step: quotient and decimal remainder.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the caller sequences it across cycles.
module div10_step
   import bcd_scan_ctrl_pkg::*;
(
   input  logic [DATA_W-1:0] dividend_i,
   output logic [DATA_W-1:0] quot_o,
   output logic [3:0]        rem_o
);

   assign quot_o = dividend_i / DATA_W'(10);
   assign rem_o  = 4'(dividend_i % DATA_W'(10));

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Binary to 4-digit BCD converter (one shared /10 over four steps) plus 7-segment digit scanner.
// Latency: transfer at E0, bcd/ovf/bcd_valid at E4, next transfer possible at E5.
// Backpressure: in_ready only in IDLE; in_valid seen while busy is dropped, not queued.
module bcd_scan_ctrl
   import bcd_scan_ctrl_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter bit BLANK_LZ = 1'b1
)(
   input  logic                 CLK,
   input  logic                 RST,
   bcd_scan_ctrl_if.slave       in_if,
   output logic                 busy,
   output logic [15:0]          bcd,
   output logic                 bcd_valid,
   output logic                 ovf,
   output logic [7:0]           seg,
   output logic [3:0]           dig_en
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] work_q, work_d;
   logic [1:0]        idx_q, idx_d;
   logic [11:0]       shadow_q, shadow_d;
   logic [15:0]       bcd_q, bcd_d;
   logic              ovf_q, ovf_d;
   logic              ovf_nxt_q, ovf_nxt_d;
   logic              bcd_valid_q, bcd_valid_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [1:0]        ptr_q, ptr_d;

   logic [DATA_W-1:0] quot;
   logic [3:0]        rem;
   logic [3:0]        digit;
   logic              blank;

   div10_step u_div10 (
      .dividend_i (work_q),
      .quot_o     (quot),
      .rem_o      (rem)
   );

   // Conversion FSM: load saturated value, peel one decimal digit per cycle, commit on the last
   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      bcd_d       = bcd_q;
      ovf_d       = ovf_q;
      ovf_nxt_d   = ovf_nxt_q;
      bcd_valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_if.in_valid) begin
               work_d    = (in_if.in_data > BCD_MAX) ? BCD_MAX : in_if.in_data;
               ovf_nxt_d = (in_if.in_data > BCD_MAX);
               idx_d     = 2'd0;
               state_d   = ST_CONV;
            end
         end
         ST_CONV: begin
            work_d = quot;
            idx_d  = idx_q + 2'd1;
            case (idx_q)
               2'd0: shadow_d[3:0]  = rem;
               2'd1: shadow_d[7:4]  = rem;
               2'd2: shadow_d[11:8] = rem;
               default: begin
                  // Thousands digit goes straight in so the display never sees a partial value
                  bcd_d       = {rem, shadow_q};
                  ovf_d       = ovf_nxt_q;
                  bcd_valid_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            endcase
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Scan prescaler and digit pointer, free-running and independent of the FSM
   always_comb begin
      presc_d = presc_q + PW'(1);
      ptr_d   = ptr_q;
      if (presc_q == PRESC_LAST) begin
         presc_d = '0;
         ptr_d   = ptr_q + 2'd1;
      end
   end

   // State registers with synchronous active-low reset; reset aborts any conversion in flight
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= ST_IDLE;
         work_q      <= '0;
         idx_q       <= '0;
         shadow_q    <= '0;
         bcd_q       <= '0;
         ovf_q       <= 1'b0;
         ovf_nxt_q   <= 1'b0;
         bcd_valid_q <= 1'b0;
         presc_q     <= '0;
         ptr_q       <= '0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         bcd_q       <= bcd_d;
         ovf_q       <= ovf_d;
         ovf_nxt_q   <= ovf_nxt_d;
         bcd_valid_q <= bcd_valid_d;
         presc_q     <= presc_d;
         ptr_q       <= ptr_d;
      end
   end

   // Segment decode for the current slot, blanking zeros above the highest significant digit
   always_comb begin
      digit = bcd_q[3:0];
      blank = 1'b0;
      case (ptr_q)
         2'd0: digit = bcd_q[3:0];
         2'd1: begin
            digit = bcd_q[7:4];
            blank = (bcd_q[15:4] == 12'd0);
         end
         2'd2: begin
            digit = bcd_q[11:8];
            blank = (bcd_q[15:8] == 8'd0);
         end
         default: begin
            digit = bcd_q[15:12];
            blank = (bcd_q[15:12] == 4'd0);
         end
      endcase
      seg    = (BLANK_LZ && blank) ? SEG_BLANK : seg_pattern(digit);
      dig_en = 4'b0001 << ptr_q;
   end

   assign in_if.in_ready = (state_q == ST_IDLE);
   assign busy           = (state_q != ST_IDLE);
   assign bcd            = bcd_q;
   assign bcd_valid      = bcd_valid_q;
   assign ovf            = ovf_q;

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl with SCAN_DIV = 4 and leading-zero blanking on.
module tb_bcd_scan_ctrl;

   typedef struct {
      logic [13:0] value;
      logic [15:0] exp_bcd;
      logic        exp_ovf;
      logic [31:0] exp_seg;   // {digit3, digit2, digit1, digit0} patterns
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        busy;
   logic [15:0] bcd;
   logic        bcd_valid;
   logic        ovf;
   logic [7:0]  seg;
   logic [3:0]  dig_en;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference scan position, advanced by the bench's own prescaler count
   int          m_presc = 0;
   logic [1:0]  m_ptr   = 2'd0;

   vec_t vecs [11];

   always #5 clk = ~clk;

   bcd_scan_ctrl_if u_if ();

   bcd_scan_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
      .CLK       (clk),
      .RST       (rst_n),
      .in_if     (u_if.slave),
      .busy      (busy),
      .bcd       (bcd),
      .bcd_valid (bcd_valid),
      .ovf       (ovf),
      .seg       (seg),
      .dig_en    (dig_en)
   );

   always @(posedge clk) begin
      if (!rst_n) begin
         m_presc <= 0;
         m_ptr   <= 2'd0;
      end else if (m_presc == 3) begin
         m_presc <= 0;
         m_ptr   <= m_ptr + 2'd1;
      end else begin
         m_presc <= m_presc + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Called just after a negedge with the DUT idle; ends just after the negedge following E5
   task automatic convert(input vec_t v);
      u_if.in_valid = 1'b1;
      u_if.in_data  = v.value;
      @(posedge clk);
      @(negedge clk);
      u_if.in_valid = 1'b0;
      check($sformatf("ready_low_after_E0 v=%0d", v.value), {31'd0, u_if.in_ready}, 32'd0);
      check($sformatf("busy_after_E0 v=%0d", v.value), {31'd0, busy}, 32'd1);
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("no_valid_E%0d v=%0d", e, v.value), {31'd0, bcd_valid}, 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
      check($sformatf("valid_E4 v=%0d", v.value), {31'd0, bcd_valid}, 32'd1);
      check($sformatf("bcd_E4 v=%0d", v.value), {16'd0, bcd}, {16'd0, v.exp_bcd});
      check($sformatf("ovf_E4 v=%0d", v.value), {31'd0, ovf}, {31'd0, v.exp_ovf});
      check($sformatf("ready_E4 v=%0d", v.value), {31'd0, u_if.in_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("valid_drop_E5 v=%0d", v.value), {31'd0, bcd_valid}, 32'd0);
   endtask

   // One full frame: each slot must select the expected digit and pattern
   task automatic check_scan(input string tag, input logic [31:0] exp_seg);
      for (int c = 0; c < 16; c++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("dig_en %s c=%0d", tag, c), {28'd0, dig_en}, {28'd0, 4'b0001 << m_ptr});
         check($sformatf("seg %s ptr=%0d", tag, m_ptr), {24'd0, seg}, {24'd0, exp_seg[m_ptr*8 +: 8]});
      end
   endtask

   initial begin
      int pulses;
      logic exp_vld;
      logic exp_rdy;
      logic [15:0] exp_b;

      vecs[0]  = '{14'd1234,  16'h1234, 1'b0, 32'h065B4F66};
      vecs[1]  = '{14'd12000, 16'h9999, 1'b1, 32'h6F6F6F6F};
      vecs[2]  = '{14'd5,     16'h0005, 1'b0, 32'h0000006D};
      vecs[3]  = '{14'd7,     16'h0007, 1'b0, 32'h00000007};
      vecs[4]  = '{14'd0,     16'h0000, 1'b0, 32'h0000003F};
      vecs[5]  = '{14'd1005,  16'h1005, 1'b0, 32'h063F3F6D};
      vecs[6]  = '{14'd80,    16'h0080, 1'b0, 32'h00007F3F};
      vecs[7]  = '{14'd9,     16'h0009, 1'b0, 32'h0000006F};
      vecs[8]  = '{14'd9999,  16'h9999, 1'b0, 32'h6F6F6F6F};
      vecs[9]  = '{14'd10000, 16'h9999, 1'b1, 32'h6F6F6F6F};
      vecs[10] = '{14'd16383, 16'h9999, 1'b1, 32'h6F6F6F6F};

      u_if.in_valid = 1'b0;
      u_if.in_data  = '0;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      check("rst_dig_en", {28'd0, dig_en}, 32'h1);
      check("rst_seg", {24'd0, seg}, 32'h3F);
      check("rst_bcd", {16'd0, bcd}, 32'h0);
      check("rst_ready", {31'd0, u_if.in_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_bcd_valid", {31'd0, bcd_valid}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);

      for (int i = 0; i < 11; i++) begin
         convert(vecs[i]);
         check_scan($sformatf("v=%0d", vecs[i].value), vecs[i].exp_seg);
      end

      // Back-to-back: in_valid held, in_data changing every cycle; only E0/E5/E10 values land
      pulses = 0;
      for (int k = 0; k < 16; k++) begin
         u_if.in_valid = (k <= 10);
         u_if.in_data  = (k == 0) ? 14'd1 : (k == 5) ? 14'd2 : (k == 10) ? 14'd3 : 14'(9000 + k);
         @(posedge clk);
         @(negedge clk);
         exp_vld = (k == 4) || (k == 9) || (k == 14);
         exp_rdy = (k % 5 == 4) || (k >= 14);
         exp_b   = (k == 4) ? 16'h0001 : (k == 9) ? 16'h0002 : 16'h0003;
         check($sformatf("b2b_valid E%0d", k), {31'd0, bcd_valid}, {31'd0, exp_vld});
         check($sformatf("b2b_ready E%0d", k), {31'd0, u_if.in_ready}, {31'd0, exp_rdy});
         if (exp_vld)
            check($sformatf("b2b_bcd E%0d", k), {16'd0, bcd}, {16'd0, exp_b});
         if (bcd_valid)
            pulses++;
      end
      u_if.in_valid = 1'b0;
      check("b2b_pulse_count", pulses, 32'd3);

      // Reset asserted at E2 of a conversion aborts it without committing
      u_if.in_valid = 1'b1;
      u_if.in_data  = 14'd4321;
      @(posedge clk);
      @(negedge clk);
      u_if.in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_bcd", {16'd0, bcd}, 32'h0);
      check("midrst_ready", {31'd0, u_if.in_ready}, 32'd1);
      check("midrst_valid", {31'd0, bcd_valid}, 32'd0);
      check("midrst_ovf", {31'd0, ovf}, 32'd0);
      check("midrst_dig_en", {28'd0, dig_en}, 32'h1);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("midrst_no_commit c=%0d", c), {15'd0, bcd_valid, bcd}, 32'h0);
      end
      check_scan("after_midrst", 32'h0000003F);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_scan_ctrl.md
# bcd_scan_ctrl

Sequencing controller for the 7-segment counter display path. It accepts a 14-bit binary value over a valid/ready handshake and converts it to four BCD digits using one shared divide-by-10 unit, iterated over four cycles. It then time-multiplexes the committed digits onto a single 8-bit segment bus with a one-hot digit enable. The block sits between the counter/calculator datapath and the board's four-digit FND.

## Interface
Parameters:
- SCAN_DIV, default 50000: clocks per digit slot; legal range ≥ 2.
- BLANK_LZ, default 1: when 1, leading-zero digits are blanked.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  synchronous, active-low reset.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  14  binary value to display.
- in_ready  out  1  high in IDLE; a transfer occurs when in_valid && in_ready at an edge.
- busy  out  1  ~in_ready.
- bcd  out  16  committed digits, {thousands, hundreds, tens, ones}.
- bcd_valid  out  1  one-cycle pulse when bcd updates.
- ovf  out  1  last accepted value exceeded 9999; held until the next commit.
- seg  out  8  active-high segments, bit7 = dp (always 0), bits6:0 = g..a.
- dig_en  out  4  one-hot active-high digit select; bit0 = ones.

## Operation
- FSM states:
  - IDLE: in_ready = 1. On a transfer, load the work register with min(in_data, 9999), capture ovf_next = (in_data > 9999), set idx = 0, and go to CONV.
  - CONV: each cycle, work ← work/10 and shadow digit[idx] ← work%10, then idx++. After the step with idx = 3, go to IDLE.
  - Commit on the idx = 3 step: write the shadow digits, with that cycle's remainder included, into bcd; set ovf; set bcd_valid = 1 for the following cycle.
- in_valid while busy is ignored and not queued. in_data is sampled only at the transfer edge.
- The display keeps showing the old bcd until the commit. Digits never tear.
- Arithmetic: work is 14 bits and the remainder is 4 bits. Saturation keeps every remainder ≤ 9.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and ptr advances 0→1→2→3→0.
  - dig_en = 1 << ptr. seg = pattern(bcd digit[ptr]).
  - Patterns: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Blanking: if BLANK_LZ = 1 and ptr > 0 and all digits at index ≥ ptr are 0, seg = 00. Digit 0 is never blanked.
- The scan runs continuously and is independent of the FSM. A commit mid-slot takes effect on seg immediately for the current ptr.

## Timing
- Reset values (RST low at an edge):
  - state IDLE, in_ready 1, busy 0
  - bcd 0000, bcd_valid 0, ovf 0
  - prescaler 0, ptr 0, dig_en 0001, seg 3F
- Conversion latency: with the transfer at edge E0, CONV steps occur at E1..E4. bcd and ovf update at E4. bcd_valid is high between E4 and E5. in_ready returns high after E4, so the earliest next transfer is at E5.
- Throughput is one value per 5 cycles with in_valid held high.
- seg and dig_en are combinational from registers only; there is no path from in_* to outputs.
- A full scan frame is 4·SCAN_DIV cycles.
- Reset mid-CONV aborts the conversion with no commit. All outputs take their reset values after that edge.

## Structure
- The shared package holds:
  - the FSM state enum (IDLE, CONV)
  - the segment pattern constants and SEG_BLANK
  - BCD_MAX = 9999
  - the data width constant 14
- One sub-module, div10_step: combinational 14-bit ÷10, producing a 14-bit quotient and a 4-bit remainder. It is instantiated exactly once and time-shared across the four CONV cycles.

## Test plan
- Reset: hold RST low for 2 cycles, then release → dig_en 0001, seg 3F, bcd 0000, in_ready 1, bcd_valid 0.
- Convert 1234 with SCAN_DIV = 4 → bcd 0x1234 at E4 with a single bcd_valid pulse. The scan shows seg 66, 4F, 5B, 06 on dig_en 0001, 0010, 0100, 1000, each held 4 cycles.
- Overflow: in_data 12000 → bcd 0x9999, ovf 1. Then in_data 5 → ovf 0.
- Blanking with BLANK_LZ = 1:
  - value 7 → seg 07 on digit 0 and 00 on digits 1–3.
  - value 0 → 3F on digit 0 only.
  - value 1005 → digit 2 shows 3F (not blanked).
- Back-to-back: in_valid held high with values 1, 2, 3 → transfers only at E0, E5, E10. Values presented while busy are not accepted, and exactly three bcd_valid pulses occur.
- Reset mid-CONV: drive RST low at E2 of a conversion of 4321 → no commit, bcd 0000, in_ready 1 on the next cycle.
